// File: rtl/video_pkg.sv
// Shared constants for the video colour-mode pipeline: mode encodings,
// BT.601-style luma weights (sum to 256) and the datapath latency.
package video_pkg;

    localparam logic [2:0] MODE_BYPASS = 3'd0;
    localparam logic [2:0] MODE_INVERT = 3'd1;
    localparam logic [2:0] MODE_GRAY   = 3'd2;
    localparam logic [2:0] MODE_THRESH = 3'd3;
    localparam logic [2:0] MODE_SWAP   = 3'd4;

    localparam int Y_CR = 77;
    localparam int Y_CG = 150;
    localparam int Y_CB = 29;

    localparam int PIPE_LAT = 3;

endpackage

// File: rtl/video_fmt_meas.sv
// Active-format measurement: pixels per line and lines per frame, latched on
// each asserted vs edge, with a lock flag for two identical consecutive frames.
module video_fmt_meas #(
    parameter int HCW      = 12,
    parameter int VCW      = 12,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dv_i,
    input  logic           vs_i,
    output logic [HCW-1:0] h_active_o,
    output logic [VCW-1:0] v_active_o,
    output logic           locked_o
);

    logic           dv_q, vs_act_q;
    logic           dv_fall, vs_edge, lock_d;
    logic [HCW-1:0] px_cnt_q, px_cnt_d, line_len_q, line_len_d, h_q;
    logic [VCW-1:0] line_cnt_q, line_cnt_d, lines_done, v_q;
    logic           lock_q;

    assign dv_fall = dv_q & ~dv_i;
    assign vs_edge = (vs_i == SYNC_POL) & ~vs_act_q;

    // lines_done already includes a line ending on this very cycle, so a
    // dv fall coinciding with the vs edge is counted into the ending frame.
    always_comb begin
        px_cnt_d = px_cnt_q;
        if (dv_fall)
            px_cnt_d = '0;
        else if (dv_i && (px_cnt_q != '1))
            px_cnt_d = px_cnt_q + HCW'(1);
        line_len_d = dv_fall ? px_cnt_q : line_len_q;
        lines_done = (dv_fall && (line_cnt_q != '1)) ? line_cnt_q + VCW'(1) : line_cnt_q;
        line_cnt_d = vs_edge ? '0 : lines_done;
        lock_d     = (line_len_d == h_q) && (lines_done == v_q) && ((h_q != '0) || (v_q != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q       <= 1'b0;
            vs_act_q   <= 1'b0;
            px_cnt_q   <= '0;
            line_len_q <= '0;
            line_cnt_q <= '0;
            h_q        <= '0;
            v_q        <= '0;
            lock_q     <= 1'b0;
        end else begin
            dv_q       <= dv_i;
            vs_act_q   <= (vs_i == SYNC_POL);
            px_cnt_q   <= px_cnt_d;
            line_len_q <= line_len_d;
            line_cnt_q <= line_cnt_d;
            if (vs_edge) begin
                h_q    <= line_len_d;
                v_q    <= lines_done;
                lock_q <= lock_d;
            end
        end
    end

    assign h_active_o = h_q;
    assign v_active_o = v_q;
    assign locked_o   = lock_q;

endmodule

// File: rtl/video_mode_proc.sv
// Per-frame colour-mode stage: 3-cycle RGB datapath (products, luma, mode mux),
// matching control delay line, frame-synchronous mode latch and format meter.
module video_mode_proc
    import video_pkg::*;
#(
    parameter int DW       = 8,
    parameter int HCW      = 12,
    parameter int VCW      = 12,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     mode,
    input  logic [DW-1:0]  thr,
    input  logic [DW-1:0]  rx_red,
    input  logic [DW-1:0]  rx_green,
    input  logic [DW-1:0]  rx_blue,
    input  logic           rx_dv,
    input  logic           rx_hs,
    input  logic           rx_vs,
    output logic [DW-1:0]  tx_red,
    output logic [DW-1:0]  tx_green,
    output logic [DW-1:0]  tx_blue,
    output logic           tx_dv,
    output logic           tx_hs,
    output logic           tx_vs,
    output logic [HCW-1:0] h_active,
    output logic [VCW-1:0] v_active,
    output logic           fmt_locked,
    output logic [2:0]     cur_mode
);

    localparam logic [DW+7:0] KR = (DW+8)'(Y_CR);
    localparam logic [DW+7:0] KG = (DW+8)'(Y_CG);
    localparam logic [DW+7:0] KB = (DW+8)'(Y_CB);

    logic          vs_act_q, vs_edge;
    logic [2:0]    cur_mode_q, mode_d;
    logic [DW-1:0] r1_q, g1_q, b1_q, thr1_q;
    logic [DW+7:0] pr1_q, pg1_q, pb1_q;
    logic [2:0]    mode1_q, ctl1_q;
    logic [DW+9:0] sum_d;
    logic [DW-1:0] r2_q, g2_q, b2_q, y2_q;
    logic          ge2_q;
    logic [2:0]    mode2_q, ctl2_q;
    logic [DW-1:0] r3_d, g3_d, b3_d, r3_q, g3_q, b3_q;
    logic [2:0]    ctl3_q;

    assign vs_edge = (rx_vs == SYNC_POL) & ~vs_act_q;
    // A pixel arriving on the vs edge already uses the newly sampled mode.
    assign mode_d  = vs_edge ? mode : cur_mode_q;
    assign sum_d   = {2'b00, pr1_q} + {2'b00, pg1_q} + {2'b00, pb1_q};

    always_comb begin
        r3_d = r2_q;
        g3_d = g2_q;
        b3_d = b2_q;
        case (mode2_q)
            MODE_INVERT: begin r3_d = ~r2_q; g3_d = ~g2_q; b3_d = ~b2_q; end
            MODE_GRAY:   begin r3_d = y2_q;  g3_d = y2_q;  b3_d = y2_q;  end
            MODE_THRESH: begin
                r3_d = ge2_q ? '1 : '0;
                g3_d = r3_d;
                b3_d = r3_d;
            end
            MODE_SWAP:   begin r3_d = b2_q;  b3_d = r2_q;  end
            default: ;
        endcase
        if (!ctl2_q[2]) begin
            r3_d = '0;
            g3_d = '0;
            b3_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_act_q   <= 1'b0;
            cur_mode_q <= '0;
            {r1_q, g1_q, b1_q, thr1_q}  <= '0;
            {pr1_q, pg1_q, pb1_q}       <= '0;
            {mode1_q, ctl1_q}           <= '0;
            {r2_q, g2_q, b2_q, y2_q}    <= '0;
            {ge2_q, mode2_q, ctl2_q}    <= '0;
            {r3_q, g3_q, b3_q, ctl3_q}  <= '0;
        end else begin
            vs_act_q   <= (rx_vs == SYNC_POL);
            cur_mode_q <= mode_d;
            r1_q    <= rx_red;
            g1_q    <= rx_green;
            b1_q    <= rx_blue;
            thr1_q  <= thr;
            pr1_q   <= (DW+8)'(rx_red) * KR;
            pg1_q   <= (DW+8)'(rx_green) * KG;
            pb1_q   <= (DW+8)'(rx_blue) * KB;
            mode1_q <= mode_d;
            ctl1_q  <= {rx_dv, rx_hs, rx_vs};
            r2_q    <= r1_q;
            g2_q    <= g1_q;
            b2_q    <= b1_q;
            y2_q    <= sum_d[DW+7:8];
            ge2_q   <= (sum_d[DW+7:8] >= thr1_q);
            mode2_q <= mode1_q;
            ctl2_q  <= ctl1_q;
            r3_q    <= r3_d;
            g3_q    <= g3_d;
            b3_q    <= b3_d;
            ctl3_q  <= ctl2_q;
        end
    end

    assign tx_red   = r3_q;
    assign tx_green = g3_q;
    assign tx_blue  = b3_q;
    assign {tx_dv, tx_hs, tx_vs} = ctl3_q;
    assign cur_mode = cur_mode_q;

    video_fmt_meas #(
        .HCW      (HCW),
        .VCW      (VCW),
        .SYNC_POL (SYNC_POL)
    ) u_fmt (
        .clk        (clk),
        .rst        (rst),
        .dv_i       (rx_dv),
        .vs_i       (rx_vs),
        .h_active_o (h_active),
        .v_active_o (v_active),
        .locked_o   (fmt_locked)
    );

endmodule

// File: tb/tb_video_mode_proc.sv
// Bench for video_mode_proc: random and directed pixels against an arithmetic
// colour model, frame-level format expectations, and a DW=10/HCW=4 build.
module tb_video_mode_proc;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic [7:0]  thr, rx_red, rx_green, rx_blue;
    logic        rx_dv, rx_hs, rx_vs;
    logic [7:0]  tx_red, tx_green, tx_blue;
    logic        tx_dv, tx_hs, tx_vs;
    logic [11:0] h_active, v_active;
    logic        fmt_locked;
    logic [2:0]  cur_mode;

    logic        rst2;
    logic [2:0]  mode2;
    logic [9:0]  thr2, r2, g2, b2, tr2, tg2, tb2;
    logic        dv2, hs2, vs2, tdv2, ths2, tvs2, lock2;
    logic [3:0]  h2;
    logic [11:0] v2;
    logic [2:0]  cm2;

    int total = 0;
    int bad   = 0;

    logic [26:0] expq[$];
    int          m_mode, m_vs_prev;
    int          p_h, p_v;

    always #5 clk = ~clk;

    video_mode_proc dut (
        .clk(clk), .rst(rst), .mode(mode), .thr(thr),
        .rx_red(rx_red), .rx_green(rx_green), .rx_blue(rx_blue),
        .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
        .tx_red(tx_red), .tx_green(tx_green), .tx_blue(tx_blue),
        .tx_dv(tx_dv), .tx_hs(tx_hs), .tx_vs(tx_vs),
        .h_active(h_active), .v_active(v_active),
        .fmt_locked(fmt_locked), .cur_mode(cur_mode)
    );

    video_mode_proc #(.DW(10), .HCW(4), .VCW(12), .SYNC_POL(1'b1)) dut10 (
        .clk(clk), .rst(rst2), .mode(mode2), .thr(thr2),
        .rx_red(r2), .rx_green(g2), .rx_blue(b2),
        .rx_dv(dv2), .rx_hs(hs2), .rx_vs(vs2),
        .tx_red(tr2), .tx_green(tg2), .tx_blue(tb2),
        .tx_dv(tdv2), .tx_hs(ths2), .tx_vs(tvs2),
        .h_active(h2), .v_active(v2),
        .fmt_locked(lock2), .cur_mode(cm2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] model(input int md, input int th, input int r, input int g,
                                          input int b, input bit dv, input bit hs, input bit vs);
        int y, o_r, o_g, o_b;
        y = (77 * r + 150 * g + 29 * b) / 256;
        o_r = r; o_g = g; o_b = b;
        case (md)
            1: begin o_r = 255 - r; o_g = 255 - g; o_b = 255 - b; end
            2: begin o_r = y; o_g = y; o_b = y; end
            3: begin o_r = (y >= th) ? 255 : 0; o_g = o_r; o_b = o_r; end
            4: begin o_r = b; o_b = r; end
            default: ;
        endcase
        if (!dv) begin o_r = 0; o_g = 0; o_b = 0; end
        return {8'(o_r), 8'(o_g), 8'(o_b), dv, hs, vs};
    endfunction

    task automatic step(input int r, input int g, input int b, input bit dv, input bit hs, input bit vs);
        logic [26:0] e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("pipe", {5'b0, tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs}, {5'b0, e});
        end
        rx_red = 8'(r); rx_green = 8'(g); rx_blue = 8'(b);
        rx_dv = dv; rx_hs = hs; rx_vs = vs;
        if (vs && !m_vs_prev) m_mode = int'(mode);
        m_vs_prev = vs;
        expq.push_back(model(m_mode, int'(thr), r, g, b, dv, hs, vs));
        @(posedge clk); #1;
    endtask

    task automatic rstep(input bit dv);
        step($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             dv, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic vs_pulse();
        step(0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_pix", {5'b0, tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs}, 32'h0);
        check("rst_fmt", {7'b0, h_active, v_active, fmt_locked}, 32'h0);
        check("rst_mode", {29'b0, cur_mode}, 32'h0);
        rst = 1'b0;
        expq.delete();
        repeat (3) expq.push_back('0);
        m_mode = 0; m_vs_prev = 0; p_h = 0; p_v = 0;
    endtask

    task automatic lines(input int npx, input int nl, input bit tight);
        for (int l = 0; l < nl; l++) begin
            step(0, 0, 0, 1'b0, 1'b1, 1'b0);
            step(0, 0, 0, 1'b0, 1'b0, 1'b0);
            repeat (npx) rstep(1'b1);
            if (!(tight && l == nl - 1)) begin
                step(0, 0, 0, 1'b0, 1'b0, 1'b0);
                step(0, 0, 0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    // Called right after vs_pulse: expected pair comes from the frame just sent.
    task automatic fmt_check(input string tag, input int h, input int v);
        bit lk;
        lk = (h == p_h) && (v == p_v) && ((p_h != 0) || (p_v != 0));
        check(tag, {7'b0, h_active, v_active, fmt_locked}, {7'b0, 12'(h), 12'(v), lk});
        p_h = h; p_v = v;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        mode = 3'd0; thr = 8'd0;
        rx_red = '0; rx_green = '0; rx_blue = '0; rx_dv = 0; rx_hs = 0; rx_vs = 0;
        mode2 = 3'd0; thr2 = '0; r2 = '0; g2 = '0; b2 = '0; dv2 = 0; hs2 = 0; vs2 = 0;
        m_mode = 0; m_vs_prev = 0; p_h = 0; p_v = 0;
        repeat (2) @(posedge clk); #1;
        do_reset();

        // Bypass with delayed syncs, then a known pixel
        step(8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 1'b0);
        step(0, 0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("bypass_px", {8'b0, tx_red, tx_green, tx_blue}, 32'h00123456);
        check("bypass_ctl", {29'b0, tx_dv, tx_hs, tx_vs}, 32'h6);

        mode = 3'd2;
        vs_pulse();
        check("cur_mode_gray", {29'b0, cur_mode}, 32'd2);
        step(255, 255, 255, 1'b1, 1'b0, 1'b0);
        step(255, 0, 0, 1'b1, 1'b0, 1'b0);
        step(0, 255, 0, 1'b1, 1'b0, 1'b0);
        check("gray_white", {8'b0, tx_red, tx_green, tx_blue}, 32'h00FFFFFF);
        step(0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("gray_red", {8'b0, tx_red, tx_green, tx_blue}, {8'b0, {3{8'd76}}});
        step(0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("gray_green", {8'b0, tx_red, tx_green, tx_blue}, {8'b0, {3{8'd149}}});

        mode = 3'd3; thr = 8'd100;
        vs_pulse();
        step(0, 255, 0, 1'b1, 1'b0, 1'b0);
        step(255, 0, 0, 1'b1, 1'b0, 1'b0);
        step(0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("thr_hi", {8'b0, tx_red, tx_green, tx_blue}, 32'h00FFFFFF);
        step(0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("thr_lo", {8'b0, tx_red, tx_green, tx_blue}, 32'h0);

        for (int m = 0; m < 8; m++) begin
            mode = 3'(m);
            thr = 8'($urandom_range(0, 255));
            vs_pulse();
            check("cur_mode_rand", {29'b0, cur_mode}, 32'(m));
            repeat (30) rstep(1'($urandom_range(0, 1)));
        end

        // Mid-frame mode change only takes effect at the next vs edge
        mode = 3'd0;
        vs_pulse();
        repeat (4) rstep(1'b1);
        mode = 3'd1;
        repeat (4) rstep(1'b1);
        check("mode_hold", {29'b0, cur_mode}, 32'd0);
        vs_pulse();
        check("mode_switch", {29'b0, cur_mode}, 32'd1);
        step(8'h10, 8'h20, 8'h30, 1'b1, 1'b0, 1'b0);
        step(0, 0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("invert_px", {8'b0, tx_red, tx_green, tx_blue}, 32'h00EFDFCF);

        // Format measurement on a clean start
        do_reset();
        mode = 3'd4;
        vs_pulse();
        fmt_check("fmt_empty", 0, 0);
        lines(20, 10, 1'b0);
        vs_pulse();
        fmt_check("fmt_f1", 20, 10);
        lines(20, 10, 1'b0);
        vs_pulse();
        fmt_check("fmt_f2_lock", 20, 10);
        lines(20, 9, 1'b0);
        vs_pulse();
        fmt_check("fmt_f3_short", 20, 9);
        lines(20, 9, 1'b1);
        vs_pulse();
        fmt_check("fmt_tight", 20, 9);
        check("cur_mode_swap", {29'b0, cur_mode}, 32'd4);
        step(0, 0, 0, 1'b0, 1'b1, 1'b0);
        repeat (7) rstep(1'b1);
        do_reset();
        repeat (4) step(0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Wide build: luma without overflow and pixel-counter saturation
        rst2 = 1'b0;
        mode2 = 3'd2;
        vs2 = 1'b1;
        @(posedge clk); #1;
        vs2 = 1'b0;
        r2 = 10'd1023; g2 = 10'd1023; b2 = 10'd1023; dv2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 2)
                check("dw10_gray", {1'b0, tdv2, tr2, tg2, tb2}, {1'b0, 1'b1, {3{10'd1023}}});
        end
        dv2 = 1'b0;
        @(posedge clk); #1;
        vs2 = 1'b1;
        @(posedge clk); #1;
        vs2 = 1'b0;
        check("hcw4_sat", {15'b0, h2, v2, lock2}, {15'b0, 4'd15, 12'd1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_mode_proc.md
# video_mode_proc

Parametrised pixel-processing stage between `hdmi_rx` and `hdmi_tx` in the `rx_clk` domain; successor to the fixed-function filter slot. Applies one of several per-frame selectable colour modes (bypass, invert, grayscale, threshold, R/B swap) to a `DW`-bit-per-channel RGB stream. Delays `dv`/`hs`/`vs` to match the pipeline and measures the incoming active format (pixels per line, lines per frame) with a lock flag.

## Interface
Parameters:
- `DW`, 8: bits per colour channel (4..12).
- `HCW`, 12: width of the pixel-per-line counter.
- `VCW`, 12: width of the line-per-frame counter.
- `SYNC_POL`, 1: asserted level of `hs`/`vs` (1 = active-high).

Ports:
- `clk`  in  1  pixel clock (`rx_clk`).
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  3  requested mode; quasi-static (switches).
- `thr`  in  DW  threshold for mode 3.
- `rx_red`, `rx_green`, `rx_blue`  in  DW each  input pixel.
- `rx_dv`, `rx_hs`, `rx_vs`  in  1  input data-valid and syncs.
- `tx_red`, `tx_green`, `tx_blue`  out  DW each  processed pixel.
- `tx_dv`, `tx_hs`, `tx_vs`  out  1  delayed controls.
- `h_active`  out  HCW  last measured active pixels per line.
- `v_active`  out  VCW  last measured active lines per frame.
- `fmt_locked`  out  1  two consecutive frames had identical `h_active`/`v_active`.
- `cur_mode`  out  3  mode currently applied.

One clock; reset is synchronous and active-high.

## Operation
- Mode encodings: 0 bypass; 1 invert (each channel = max − x); 2 grayscale (all channels = Y); 3 threshold (all channels = Y ≥ `thr` ? all-ones : 0); 4 swap (R↔B, G unchanged); 5–7 treated as bypass; `cur_mode` reports the raw latched value.
- Y = (77·R + 150·G + 29·B) >> 8. Products are DW+8 bits and the sum is DW+10 bits. Take bits [DW+7:8]. No saturation is needed: the max sum is 256·(2^DW−1).
- Mode latch: `mode` is sampled into `cur_mode` only on the cycle `rx_vs` transitions to its asserted level. A mid-frame `mode` change takes effect on the next frame. After reset `cur_mode` = 0 until the first vs edge.
- Blanking: when the delayed `dv` is 0, the tx colour outputs are 0 regardless of mode.
- Format measurement (sub-module):
  - The pixel counter increments on each `rx_dv`=1 cycle and saturates at all-ones.
  - On the falling edge of `rx_dv`: latch the pixel count into the line-length register, clear the counter, and increment the line counter (saturating).
  - On the asserted vs edge: `h_active` ← line length, `v_active` ← line count, and the line counter is cleared.
  - On that same edge, `fmt_locked` ← (new pair == previous pair) && previous pair nonzero.
- Simultaneous dv fall and vs edge: the line is counted into the ending frame before `v_active` is latched.

## Timing
- Data path latency is exactly 3 cycles:
  - S1 registers inputs and the products.
  - S2 computes the sum/Y and the threshold compare.
  - S3 is the mode mux and output register.
- `tx_dv`/`tx_hs`/`tx_vs` are the inputs delayed by 3 flops each and are always aligned with the colour outputs.
- The mode used for a pixel is `cur_mode` as sampled when that pixel enters S1. A vs edge switches the mode at the frame boundary pixel-exactly.
- Measurement outputs update 1 cycle after the triggering edge cycle.
- Reset (including mid-frame) clears all pipeline stages, edge detectors and counters, and drives every output to 0: colours, controls, `h_active`, `v_active`, `fmt_locked`, `cur_mode`. The first output after reset appears 3 cycles after the first post-reset input.
- With `SYNC_POL`=0, edges are detected on the falling transition and the syncs pass through unmodified.

## Structure
- Package `video_pkg`:
  - mode encodings `MODE_BYPASS`..`MODE_SWAP`;
  - luma coefficients `Y_CR`=77, `Y_CG`=150, `Y_CB`=29;
  - `PIPE_LAT`=3.
- Sub-module `video_fmt_meas` (parameters HCW, VCW, SYNC_POL) holds the counters, edge detectors and lock compare. It is shared later with a status/OSD block.
- The top holds the mode latch, the 3-stage datapath and the control delay line.

## Test plan
- Reset, then bypass: pixel (0x12,0x34,0x56) with dv=1 at cycle t → same value on tx at t+3, `tx_dv`=1 at t+3, syncs delayed 3.
- Grayscale: (255,255,255) → (255,255,255); (255,0,0) → (76,76,76); (0,255,0) → (149,149,149). Threshold with `thr`=100: (0,255,0) → (255,255,255); (255,0,0) → (0,0,0).
- Mode change from 0 to 1 mid-frame → `cur_mode` stays 0 until the next vs edge. From the first pixel after that edge, (0x10,0x20,0x30) → (0xEF,0xDF,0xCF).
- Format: two frames of 640 dv-cycles × 480 lines → `h_active`=640, `v_active`=480 after frame 1 with `fmt_locked`=0. After frame 2, `fmt_locked`=1. A 479-line third frame → `fmt_locked`=0.
- Simultaneous dv fall and vs edge on the last line → the line is counted (`v_active`=480). Reset asserted mid-line → all outputs 0 next cycle and `cur_mode`=0.
- DW=10 build: grayscale of (1023,1023,1023) → 1023 on all channels, no overflow; counter saturation with HCW=4 and a 20-pixel line → `h_active`=15.
